// File: rtl/yc_separator_pipelined.sv
// Pipelined composite Y/C separator: boxcar low-pass luma, centre-tap high-pass chroma.
// Three-stage stream pipeline with per-sample mode, flush, primed flag and chroma saturation.
module yc_separator_pipelined #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned LOG2_WINDOW = 5,
  parameter int unsigned ACC_WIDTH   = DATA_WIDTH + LOG2_WINDOW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic        [1:0]            mode,
  input  logic                         flush,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] luma_out,
  output logic signed [DATA_WIDTH-1:0] chroma_out,
  output logic                         primed
);

  localparam int unsigned W   = 1 << LOG2_WINDOW;
  localparam int unsigned CW  = LOG2_WINDOW + 1;
  localparam int unsigned DW1 = DATA_WIDTH + 1;

  localparam logic [1:0] MODE_BYPASS = 2'b01;
  localparam logic [1:0] MODE_LUMA   = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  // Stage 1: history, running sum, prime count
  logic signed [DATA_WIDTH-1:0] hist [W];
  logic signed [ACC_WIDTH-1:0]  sum;
  logic        [CW-1:0]         cnt;
  logic                         v1;
  logic        [1:0]            mode1;

  // Stage 2: low-pass, centre difference
  logic                         v2;
  logic        [1:0]            mode2;
  logic signed [DATA_WIDTH-1:0] x2;
  logic signed [DATA_WIDTH-1:0] l2;
  logic signed [DW1-1:0]        d2;
  logic                         p2;

  logic signed [DATA_WIDTH-1:0] lp_c;
  logic signed [DATA_WIDTH-1:0] centre_c;
  logic signed [DATA_WIDTH-1:0] sat_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < W; i++) hist[i] <= '0;
      sum   <= '0;
      cnt   <= '0;
      v1    <= 1'b0;
      mode1 <= '0;
    end else if (flush) begin
      for (int i = 0; i < W; i++) hist[i] <= '0;
      sum   <= '0;
      cnt   <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        hist[0] <= data_in;
        for (int i = 1; i < W; i++) hist[i] <= hist[i-1];
        sum   <= sum + ACC_WIDTH'(data_in) - ACC_WIDTH'(hist[W-1]);
        mode1 <= mode;
        if (cnt != CW'(W)) cnt <= cnt + CW'(1);
      end
    end
  end

  // Floor shift of the sum always fits DATA_WIDTH, so take the slice directly
  assign lp_c     = sum[DATA_WIDTH+LOG2_WINDOW-1:LOG2_WINDOW];
  assign centre_c = hist[W/2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      mode2 <= '0;
      x2    <= '0;
      l2    <= '0;
      d2    <= '0;
      p2    <= 1'b0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        mode2 <= mode1;
        x2    <= hist[0];
        l2    <= lp_c;
        p2    <= (cnt == CW'(W));
        if (mode1 == MODE_INVERT) d2 <= DW1'(lp_c) - DW1'(centre_c);
        else                      d2 <= DW1'(centre_c) - DW1'(lp_c);
      end
    end
  end

  // Clamp the DW+1 bit difference into DATA_WIDTH
  always_comb begin
    sat_c = d2[DATA_WIDTH-1:0];
    if (d2[DW1-1] != d2[DW1-2])
      sat_c = d2[DW1-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      luma_out   <= '0;
      chroma_out <= '0;
      primed     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        primed <= p2;
        case (mode2)
          MODE_BYPASS: begin
            luma_out   <= x2;
            chroma_out <= '0;
          end
          MODE_LUMA: begin
            luma_out   <= l2;
            chroma_out <= '0;
          end
          default: begin
            luma_out   <= l2;
            chroma_out <= sat_c;
          end
        endcase
      end
    end
  end

endmodule
